// File: rtl/demux_8by16bit_wr.sv
// demux_8by16bit_wr: steers one write stream into one of eight registered
// lanes, either by explicit lane select or by a sequential burst fill A..H.
// The lane outputs feed the 8:1 read mux directly.
// Optional build macro DEMUX_WR_BYPASS_EN: the lane being written this cycle
// shows wr_data combinationally on its output; register timing is unchanged.
module demux_8by16bit_wr #(
    parameter int                 WIDTH   = 16,
    parameter logic [WIDTH-1:0]   RST_VAL = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [2:0]       wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             burst_start,
    output logic             burst_busy,
    output logic             burst_done,
    output logic [2:0]       burst_lane,
    output logic [WIDTH-1:0] outA,
    output logic [WIDTH-1:0] outB,
    output logic [WIDTH-1:0] outC,
    output logic [WIDTH-1:0] outD,
    output logic [WIDTH-1:0] outE,
    output logic [WIDTH-1:0] outF,
    output logic [WIDTH-1:0] outG,
    output logic [WIDTH-1:0] outH
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [2:0]       lane_cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] lane_r [8];

    logic             wr_hit_s;
    logic [2:0]       wr_idx_s;
    logic [WIDTH-1:0] out_s  [8];

    // Decode which lane (if any) takes wr_data at the next edge.
    always_comb begin
        wr_hit_s = 1'b0;
        wr_idx_s = 3'd0;
        case (state_r)
            ST_IDLE: begin
                // burst_start wins over a simultaneous single write
                if (wr_en && !burst_start) begin
                    wr_hit_s = 1'b1;
                    wr_idx_s = wr_sel;
                end else begin
                    wr_hit_s = 1'b0;
                    wr_idx_s = 3'd0;
                end
            end
            ST_BURST: begin
                if (wr_en) begin
                    wr_hit_s = 1'b1;
                    wr_idx_s = lane_cnt_r;
                end else begin
                    wr_hit_s = 1'b0;
                    wr_idx_s = 3'd0;
                end
            end
            ST_DONE: begin
                // burst_start is ignored here; single writes behave as in IDLE
                if (wr_en) begin
                    wr_hit_s = 1'b1;
                    wr_idx_s = wr_sel;
                end else begin
                    wr_hit_s = 1'b0;
                    wr_idx_s = 3'd0;
                end
            end
            default: begin
                wr_hit_s = 1'b0;
                wr_idx_s = 3'd0;
            end
        endcase
    end

    // Lane storage: reset to RST_VAL, otherwise load the decoded lane.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                lane_r[i] <= RST_VAL;
            end
        end else if (wr_hit_s) begin
            lane_r[wr_idx_s] <= wr_data;
        end
    end

    // Burst controller: IDLE -> BURST -> DONE -> IDLE with registered flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            lane_cnt_r <= 3'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (burst_start) begin
                        state_r    <= ST_BURST;
                        lane_cnt_r <= 3'd0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_BURST: begin
                    // wr_en low stalls the fill indefinitely
                    if (wr_en) begin
                        if (lane_cnt_r == 3'd7) begin
                            state_r    <= ST_DONE;
                            lane_cnt_r <= 3'd0;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                        end else begin
                            lane_cnt_r <= lane_cnt_r + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    lane_cnt_r <= 3'd0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEMUX_WR_BYPASS_EN
    // Forward wr_data onto the lane being written this cycle; never during reset.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            out_s[i] = lane_r[i];
        end
        if (rst_n && wr_hit_s) begin
            out_s[wr_idx_s] = wr_data;
        end else begin
            out_s[wr_idx_s] = lane_r[wr_idx_s];
        end
    end
`else
    // Lane outputs are the registers themselves (one-cycle write-to-read).
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            out_s[i] = lane_r[i];
        end
    end
`endif

    assign outA       = out_s[0];
    assign outB       = out_s[1];
    assign outC       = out_s[2];
    assign outD       = out_s[3];
    assign outE       = out_s[4];
    assign outF       = out_s[5];
    assign outG       = out_s[6];
    assign outH       = out_s[7];
    assign burst_busy = busy_r;
    assign burst_done = done_r;
    assign burst_lane = lane_cnt_r;

endmodule
